// File: rtl/fm_eg_pkg.sv
// Shared types and rate math for the time-multiplexed FM envelope generator.
// Pure declarations; no state, no flow control.
package fm_eg_pkg;

    typedef enum logic [1:0] {
        ATTACK  = 2'd0,
        DECAY   = 2'd1,
        SUSTAIN = 2'd2,
        RELEASE = 2'd3
    } stage_t;

    typedef enum logic [1:0] {
        S_INIT,
        S_IDLE,
        S_RUN
    } fsm_t;

    localparam int MAX_RATE     = 60;
    localparam int ATTACK_SHIFT = 3;

    // Effective rate is the key-scale offset plus four steps per rate unit;
    // the increment is a 3-bit mantissa {1,frac} shifted by the rate octave.
    function automatic logic [31:0] rate_inc(input logic [3:0] rof, input logic [3:0] rate);
        logic [6:0] r7;
        r7 = {3'd0, rof} + {1'b0, rate, 2'b00};
        if (r7 > 7'(MAX_RATE)) begin
            r7 = 7'(MAX_RATE);
        end
        rate_inc = {29'd0, 1'b1, r7[1:0]} << r7[5:2];
    endfunction

endpackage

// File: rtl/fm_eg_seq_if.sv
// Sweep control, per-slot parameter and attenuation output bundle.
// master = operator sequencer side, slave = envelope generator.
interface fm_eg_seq_if #(
    parameter int NUM_SLOTS = 36,
    parameter int SLOT_W    = $clog2(NUM_SLOTS),
    parameter int ENV_W     = 9,
    parameter int TL_W      = 6
);
    logic              start;
    logic              busy;
    logic [SLOT_W-1:0] slot;
    logic [3:0]        ar;
    logic [3:0]        dr;
    logic [3:0]        sl;
    logic [3:0]        rr;
    logic [TL_W-1:0]   tl;
    logic [2:0]        block;
    logic [9:0]        fnum;
    logic              nts;
    logic              ksr;
    logic              kon;
    logic              egt;
    logic              op_reset;
    logic              env_valid;
    logic [SLOT_W-1:0] env_slot;
    logic [ENV_W-1:0]  env;

    modport master (
        output start, ar, dr, sl, rr, tl, block, fnum, nts, ksr, kon, egt, op_reset,
        input  busy, slot, env_valid, env_slot, env
    );

    modport slave (
        input  start, ar, dr, sl, rr, tl, block, fnum, nts, ksr, kon, egt, op_reset,
        output busy, slot, env_valid, env_slot, env
    );
endinterface

// File: rtl/fm_eg_slot_ram.sv
// Per-slot envelope state store: async read, sync write, shared address.
// Read data is valid in the same cycle the address is presented; no stalls.
module fm_eg_slot_ram #(
    parameter int DEPTH  = 36,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int DAT_W  = 27
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DAT_W-1:0]  wr_dat,
    output logic [DAT_W-1:0]  rd_dat
);
    logic [DAT_W-1:0] mem [DEPTH];

    assign rd_dat = mem[addr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_dat;
        end
    end
endmodule

// File: rtl/fm_eg_seq.sv
// FM envelope generator sweeping NUM_SLOTS slots, one per clock; env is registered
// one cycle after its slot is presented. No backpressure: consumers must accept every env_valid.
module fm_eg_seq
    import fm_eg_pkg::*;
#(
    parameter int NUM_SLOTS = 36,
    parameter int SLOT_W    = $clog2(NUM_SLOTS),
    parameter int CNT_W     = 24,
    parameter int ENV_W     = 9,
    parameter int TL_W      = 6
) (
    input  logic       clk,
    input  logic       reset,
    fm_eg_seq_if.slave bus
);
    localparam int                RAM_W     = 2 + CNT_W + 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_SLOTS - 1);
    localparam logic [CNT_W-1:0]  CNT_ONES  = {CNT_W{1'b1}};

    fsm_t              state;
    logic [SLOT_W-1:0] slot_q;
    logic [SLOT_W-1:0] env_slot_q;
    logic              busy_q;
    logic              env_valid_q;
    logic [ENV_W-1:0]  env_q;

    logic [RAM_W-1:0]  rd_dat;
    logic [RAM_W-1:0]  wr_dat;
    logic              wr_en;

    stage_t            st_old;
    stage_t            st_new;
    logic [CNT_W-1:0]  cnt_old;
    logic [CNT_W-1:0]  cnt_new;
    logic              kp_old;
    logic [3:0]        rof;
    logic [3:0]        rate;
    logic [CNT_W:0]    inc;
    logic [CNT_W:0]    add;
    logic [CNT_W:0]    sub;
    logic              rising;
    logic              falling;
    logic [ENV_W:0]    env_sum;
    logic [ENV_W-1:0]  env_next;
    logic              unused_fnum;

    assign unused_fnum = ^bus.fnum[7:0];

    assign st_old  = stage_t'(rd_dat[RAM_W-1 -: 2]);
    assign cnt_old = rd_dat[CNT_W:1];
    assign kp_old  = rd_dat[0];

    always_comb begin
        rof = {bus.block, (bus.nts ? bus.fnum[8] : bus.fnum[9])};
        if (bus.ksr) begin
            rof = rof >> 2;
        end
        case (st_old)
            ATTACK:  rate = bus.ar;
            DECAY:   rate = bus.dr;
            SUSTAIN: rate = bus.egt ? 4'd0 : bus.rr;
            default: rate = bus.rr;
        endcase
        inc = (CNT_W+1)'(rate_inc(rof, rate));
        if (st_old == ATTACK) begin
            inc = inc << ATTACK_SHIFT;
        end
        add     = {1'b0, cnt_old} + inc;
        sub     = {1'b0, cnt_old} - inc;
        rising  = bus.kon & ~kp_old;
        falling = ~bus.kon & kp_old;

        cnt_new = cnt_old;
        st_new  = st_old;
        // Key edges override rate stepping and keep the level, so re-triggers are click-free.
        if (bus.op_reset) begin
            cnt_new = CNT_ONES;
            st_new  = rising ? ATTACK : RELEASE;
        end else if (rising) begin
            st_new = ATTACK;
        end else if (falling && st_old != RELEASE) begin
            st_new = RELEASE;
        end else begin
            case (st_old)
                ATTACK: begin
                    if (rate != 4'd0) begin
                        if (sub[CNT_W]) begin
                            cnt_new = '0;
                            st_new  = DECAY;
                        end else begin
                            cnt_new = sub[CNT_W-1:0];
                        end
                    end
                end
                DECAY: begin
                    if (rate != 4'd0) begin
                        if (add[CNT_W] || add[CNT_W-1 -: 4] >= bus.sl) begin
                            cnt_new = {bus.sl, {(CNT_W-4){1'b0}}};
                            st_new  = SUSTAIN;
                        end else begin
                            cnt_new = add[CNT_W-1:0];
                        end
                    end
                end
                SUSTAIN: begin
                    if (!bus.kon) begin
                        st_new = RELEASE;
                    end else if (rate != 4'd0) begin
                        cnt_new = add[CNT_W] ? CNT_ONES : add[CNT_W-1:0];
                    end
                end
                default: begin
                    if (rate != 4'd0) begin
                        cnt_new = add[CNT_W] ? CNT_ONES : add[CNT_W-1:0];
                    end
                end
            endcase
        end

        env_sum  = {1'b0, cnt_new[CNT_W-1 -: ENV_W]} + ((ENV_W+1)'(bus.tl) << (ENV_W - TL_W - 1));
        env_next = env_sum[ENV_W] ? {ENV_W{1'b1}} : env_sum[ENV_W-1:0];
    end

    assign wr_en  = !reset && (state == S_INIT || state == S_RUN);
    assign wr_dat = (state == S_INIT) ? {RELEASE, CNT_ONES, 1'b0} : {st_new, cnt_new, bus.kon};

    fm_eg_slot_ram #(
        .DEPTH  (NUM_SLOTS),
        .ADDR_W (SLOT_W),
        .DAT_W  (RAM_W)
    ) u_ram (
        .clk    (clk),
        .wr_en  (wr_en),
        .addr   (slot_q),
        .wr_dat (wr_dat),
        .rd_dat (rd_dat)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_INIT;
            slot_q      <= '0;
            busy_q      <= 1'b1;
            env_valid_q <= 1'b0;
            env_q       <= '0;
            env_slot_q  <= '0;
        end else begin
            case (state)
                S_INIT: begin
                    env_valid_q <= 1'b0;
                    if (slot_q == SLOT_LAST) begin
                        slot_q <= '0;
                        busy_q <= 1'b0;
                        state  <= S_IDLE;
                    end else begin
                        slot_q <= slot_q + 1'b1;
                    end
                end
                S_IDLE: begin
                    env_valid_q <= 1'b0;
                    if (bus.start) begin
                        slot_q <= '0;
                        busy_q <= 1'b1;
                        state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    env_valid_q <= 1'b1;
                    env_slot_q  <= slot_q;
                    env_q       <= env_next;
                    if (slot_q == SLOT_LAST) begin
                        slot_q <= '0;
                        busy_q <= 1'b0;
                        state  <= S_IDLE;
                    end else begin
                        slot_q <= slot_q + 1'b1;
                    end
                end
                default: begin
                    state <= S_INIT;
                end
            endcase
        end
    end

    assign bus.slot      = slot_q;
    assign bus.busy      = busy_q;
    assign bus.env_valid = env_valid_q;
    assign bus.env_slot  = env_slot_q;
    assign bus.env       = env_q;
endmodule

// File: tb/tb_fm_eg_seq.sv
// Randomized scoreboard bench for fm_eg_seq against a behavioural envelope model.
// Expected envs are queued per sweep; a monitor pops one per env_valid.
module tb_fm_eg_seq;
    localparam int N      = 36;
    localparam int SLOT_W = $clog2(N);
    localparam int CNT_W  = 24;
    localparam int ENV_W  = 9;
    localparam int TL_W   = 6;
    localparam longint FULL    = (64'd1 << CNT_W) - 1;
    localparam int     ENV_MAX = (1 << ENV_W) - 1;
    localparam int ST_A = 0, ST_D = 1, ST_S = 2, ST_R = 3;

    typedef struct {
        int ar, dr, sl, rr, tl, blk, fnum, nts, ksr, kon, egt, opr;
    } prm_t;
    typedef struct {
        int slot;
        int env;
    } exp_t;

    logic   clk;
    logic   reset;
    prm_t   tbl [N];
    int     m_st [N];
    longint m_cnt [N];
    int     m_kp [N];
    exp_t   q [$];
    int     n_chk = 0;
    int     n_fail = 0;

    fm_eg_seq_if #(.NUM_SLOTS(N), .SLOT_W(SLOT_W), .ENV_W(ENV_W), .TL_W(TL_W)) bus ();

    fm_eg_seq #(
        .NUM_SLOTS (N),
        .SLOT_W    (SLOT_W),
        .CNT_W     (CNT_W),
        .ENV_W     (ENV_W),
        .TL_W      (TL_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input longint got, input longint want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    function automatic void model_reset();
        for (int s = 0; s < N; s++) begin
            m_st[s]  = ST_R;
            m_cnt[s] = FULL;
            m_kp[s]  = 0;
        end
    endfunction

    // Envelope behaviour expressed as integer arithmetic on the level counter.
    function automatic int model_step(input int s, input prm_t p);
        int     rof;
        int     rate;
        int     r7;
        int     e;
        longint inc;
        bit     rising;
        bit     falling;
        rof = p.blk * 2 + (p.nts != 0 ? (p.fnum >> 8) % 2 : (p.fnum >> 9) % 2);
        if (p.ksr != 0) rof = rof / 4;
        rising  = (p.kon != 0) && (m_kp[s] == 0);
        falling = (p.kon == 0) && (m_kp[s] != 0);
        if (p.opr != 0) begin
            m_cnt[s] = FULL;
            m_st[s]  = rising ? ST_A : ST_R;
        end else if (rising) begin
            m_st[s] = ST_A;
        end else if (falling && m_st[s] != ST_R) begin
            m_st[s] = ST_R;
        end else begin
            case (m_st[s])
                ST_A:    rate = p.ar;
                ST_D:    rate = p.dr;
                ST_S:    rate = (p.egt != 0) ? 0 : p.rr;
                default: rate = p.rr;
            endcase
            r7 = rof + 4 * rate;
            if (r7 > 60) r7 = 60;
            inc = longint'(4 + r7 % 4) * (64'd1 << (r7 / 4));
            if (m_st[s] == ST_S && p.kon == 0) begin
                m_st[s] = ST_R;
            end else if (rate != 0) begin
                if (m_st[s] == ST_A) begin
                    inc = inc * 8;
                    if (inc > m_cnt[s]) begin
                        m_cnt[s] = 0;
                        m_st[s]  = ST_D;
                    end else begin
                        m_cnt[s] = m_cnt[s] - inc;
                    end
                end else if (m_st[s] == ST_D) begin
                    m_cnt[s] = m_cnt[s] + inc;
                    if (m_cnt[s] > FULL || (m_cnt[s] >> (CNT_W - 4)) >= p.sl) begin
                        m_cnt[s] = longint'(p.sl) << (CNT_W - 4);
                        m_st[s]  = ST_S;
                    end
                end else begin
                    m_cnt[s] = m_cnt[s] + inc;
                    if (m_cnt[s] > FULL) m_cnt[s] = FULL;
                end
            end
        end
        m_kp[s] = p.kon;
        e = int'(m_cnt[s] >> (CNT_W - ENV_W)) + p.tl * (1 << (ENV_W - TL_W - 1));
        return (e > ENV_MAX) ? ENV_MAX : e;
    endfunction

    task automatic push_sweep(input int n_slots);
        exp_t x;
        for (int s = 0; s < n_slots; s++) begin
            x.slot = s;
            x.env  = model_step(s, tbl[s]);
            q.push_back(x);
        end
    endtask

    task automatic rand_slot(input int s, input bit keep_kon);
        tbl[s].ar   = $urandom_range(0, 15);
        tbl[s].dr   = $urandom_range(0, 15);
        tbl[s].sl   = $urandom_range(0, 15);
        tbl[s].rr   = $urandom_range(0, 15);
        tbl[s].tl   = $urandom_range(0, 63);
        tbl[s].blk  = $urandom_range(0, 7);
        tbl[s].fnum = $urandom_range(0, 1023);
        tbl[s].nts  = $urandom_range(0, 1);
        tbl[s].ksr  = $urandom_range(0, 1);
        tbl[s].egt  = $urandom_range(0, 1);
        if (keep_kon) begin
            if ($urandom_range(0, 3) == 0) tbl[s].kon = 1 - tbl[s].kon;
            tbl[s].opr = ($urandom_range(0, 15) == 0) ? 1 : 0;
        end else begin
            tbl[s].kon = 0;
            tbl[s].opr = 0;
        end
    endtask

    task automatic drive_slot(input int s);
        bus.ar       = 4'(tbl[s].ar);
        bus.dr       = 4'(tbl[s].dr);
        bus.sl       = 4'(tbl[s].sl);
        bus.rr       = 4'(tbl[s].rr);
        bus.tl       = TL_W'(tbl[s].tl);
        bus.block    = 3'(tbl[s].blk);
        bus.fnum     = 10'(tbl[s].fnum);
        bus.nts      = 1'(tbl[s].nts);
        bus.ksr      = 1'(tbl[s].ksr);
        bus.kon      = 1'(tbl[s].kon);
        bus.egt      = 1'(tbl[s].egt);
        bus.op_reset = 1'(tbl[s].opr);
    endtask

    // Parameter driver: answers whatever slot the DUT requests.
    initial begin
        for (int s = 0; s < N; s++) tbl[s] = '{default: 0};
        drive_slot(0);
        forever begin
            @(negedge clk);
            if (int'(bus.slot) < N) drive_slot(int'(bus.slot));
        end
    end

    // Monitor: every env_valid must match the head of the expected queue.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (bus.env_valid === 1'b1) begin
                n_chk++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_env: got slot %0d env %0d, want no output", bus.env_slot, bus.env);
                end else begin
                    x = q.pop_front();
                    if (int'(bus.env_slot) != x.slot || int'(bus.env) != x.env) begin
                        n_fail++;
                        $display("FAIL env_out: got slot %0d env %0d, want slot %0d env %0d", bus.env_slot, bus.env, x.slot, x.env);
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded 100000 cycles");
        $fatal(1, "watchdog expired");
    end

    task automatic count_init();
        int n;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            if (bus.busy === 1'b1) n++;
            else break;
            @(negedge clk);
        end
        check("init_busy_cycles", n, N);
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            if (bus.busy === 1'b0) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        check(name, ok, 1);
    endtask

    task automatic run_sweep(input bit extra_start);
        check("idle_before_start", bus.busy, 0);
        push_sweep(N);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        if (extra_start) begin
            repeat ($urandom_range(3, 20)) @(negedge clk);
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
        end
        wait_idle("sweep_done");
        repeat (2) @(negedge clk);
        check("queue_drained", q.size(), 0);
    endtask

    initial begin
        int hi;
        bit found;
        reset     = 1'b1;
        bus.start = 1'b0;
        model_reset();
        for (int s = 0; s < N; s++) begin
            rand_slot(s, 0);
            tbl[s].tl = 0;
        end
        repeat (3) @(negedge clk);
        check("rst_busy", bus.busy, 1);
        check("rst_env_valid", bus.env_valid, 0);
        check("rst_env", bus.env, 0);
        check("rst_env_slot", bus.env_slot, 0);
        check("rst_slot", bus.slot, 0);
        reset = 1'b0;
        count_init();
        check("idle_env_valid", bus.env_valid, 0);

        // All slots released at full attenuation.
        run_sweep(0);

        // Directed slots: 0 hard attack, 3 park at sustain then release,
        // 7 key retrigger mid-attack, 2 clamp then op_reset with key-on.
        for (int sw = 0; sw < 70; sw++) begin
            for (int s = 0; s < N; s++) rand_slot(s, 0);
            tbl[0].ar = 15; tbl[0].kon = 1; tbl[0].tl = 0;
            tbl[3].ar = 15; tbl[3].dr = 15; tbl[3].sl = 5; tbl[3].egt = 1;
            tbl[3].rr = 6;  tbl[3].tl = 0;  tbl[3].kon = (sw < 60) ? 1 : 0;
            tbl[7].ar = 12; tbl[7].kon = (sw == 6) ? 0 : 1;
            if (sw < 5) begin
                tbl[2].ar = 0; tbl[2].rr = 0; tbl[2].tl = 63;
            end else begin
                tbl[2].ar = 10; tbl[2].kon = 1; tbl[2].opr = (sw == 5) ? 1 : 0;
            end
            run_sweep(sw % 3 == 0);
        end

        // start held high: back-to-back sweeps only from IDLE.
        check("idle_before_hold", bus.busy, 0);
        for (int s = 0; s < N; s++) rand_slot(s, 1);
        push_sweep(N);
        push_sweep(N);
        push_sweep(N);
        hi = 0;
        bus.start = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (i == 80) bus.start = 1'b0;
            if (bus.busy === 1'b1) hi++;
        end
        check("held_start_busy_cycles", hi, 3 * N);
        check("held_start_queue", q.size(), 0);

        for (int sw = 0; sw < 25; sw++) begin
            for (int s = 0; s < N; s++) rand_slot(s, 1);
            run_sweep($urandom_range(0, 1) == 1);
        end

        // Reset while slot 20 is being presented aborts the sweep.
        for (int s = 0; s < N; s++) rand_slot(s, 1);
        push_sweep(20);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        found = 0;
        for (int i = 0; i < 60; i++) begin
            if (int'(bus.slot) == 20) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        check("reached_slot20", found, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_env_valid", bus.env_valid, 0);
        check("abort_busy", bus.busy, 1);
        check("abort_slot", bus.slot, 0);
        model_reset();
        count_init();
        check("abort_queue", q.size(), 0);

        for (int s = 0; s < N; s++) rand_slot(s, 1);
        run_sweep(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
